// File: rtl/pc_branch_unit.sv
// pc_branch_unit: program counter and branch-resolution stage.
// Holds the PC and the latched status flags (C,V,N,Z). On pc_write it
// either increments the PC or resolves a masked branch condition and
// loads an absolute or PC-relative target.
// Optional feature macro: PC_BRCNT_EN enables the saturating taken-branch
// counter on br_count; without it br_count is tied to zero.
module pc_branch_unit #(
  parameter int PC_W   = 16,
  parameter int STAT_W = 4
) (
  input  logic              clk,
  input  logic              pc_rst,
  input  logic              pc_write,
  input  logic              pc_sel,
  input  logic              br_sel,
  input  logic              br_neg,
  input  logic [STAT_W-1:0] cond_mask,
  input  logic [PC_W-1:0]   imm,
  input  logic              stat_en,
  input  logic [STAT_W-1:0] stat_in,
  output logic [PC_W-1:0]   pc_out,
  output logic [STAT_W-1:0] stat_out,
  output logic              br_taken,
  output logic [15:0]       br_count
);

  logic [PC_W-1:0]   pc_reg, pc_next;
  logic [STAT_W-1:0] stat_reg;
  logic              br_taken_reg, br_taken_next;
  logic [STAT_W-1:0] hit_bits;
  logic              hit;
  logic              cond;
  logic              take_event;

  // Per-flag mask test against the pre-edge status register.
  genvar gi;
  generate
    for (gi = 0; gi < STAT_W; gi++) begin : g_hit
      assign hit_bits[gi] = cond_mask[gi] & stat_reg[gi];
    end
  endgenerate

  assign hit        = |hit_bits;
  assign cond       = br_neg ? ~hit : hit;
  assign take_event = pc_write & pc_sel & cond;

  // Next PC / taken flag; a non-taken branch leaves the PC where fetch put it.
  always_comb begin
    pc_next       = pc_reg;
    br_taken_next = br_taken_reg;
    if (pc_write) begin
      if (!pc_sel) begin
        pc_next       = pc_reg + {{(PC_W-1){1'b0}}, 1'b1};
        br_taken_next = 1'b0;
      end else if (cond) begin
        // imm is already PC_W wide, so the modular add is the sign-extended add.
        pc_next       = br_sel ? (pc_reg + imm) : imm;
        br_taken_next = 1'b1;
      end else begin
        br_taken_next = 1'b0;
      end
    end
  end

  // PC and taken-flag registers.
  always_ff @(posedge clk or posedge pc_rst) begin
    if (pc_rst) begin
      pc_reg       <= '0;
      br_taken_reg <= 1'b0;
    end else begin
      pc_reg       <= pc_next;
      br_taken_reg <= br_taken_next;
    end
  end

  // Status register, loaded independently of PC updates.
  always_ff @(posedge clk or posedge pc_rst) begin
    if (pc_rst) begin
      stat_reg <= '0;
    end else if (stat_en) begin
      stat_reg <= stat_in;
    end
  end

`ifdef PC_BRCNT_EN
  logic [15:0] br_count_reg;

  // Saturating count of taken branches; only reset clears it.
  always_ff @(posedge clk or posedge pc_rst) begin
    if (pc_rst) begin
      br_count_reg <= '0;
    end else if (take_event && (br_count_reg != 16'hFFFF)) begin
      br_count_reg <= br_count_reg + 16'd1;
    end
  end

  assign br_count = br_count_reg;
`else
  logic unused_take;
  assign unused_take = take_event;
  assign br_count    = 16'h0000;
`endif

  assign pc_out   = pc_reg;
  assign stat_out = stat_reg;
  assign br_taken = br_taken_reg;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Self-checking bench for pc_branch_unit: directed steps followed by
// random strobes, compared against an arithmetic reference model.
module tb_pc_branch_unit;

  logic        clk;
  logic        pc_rst;
  logic        pc_write;
  logic        pc_sel;
  logic        br_sel;
  logic        br_neg;
  logic [3:0]  cond_mask;
  logic [15:0] imm;
  logic        stat_en;
  logic [3:0]  stat_in;
  logic [15:0] pc_out;
  logic [3:0]  stat_out;
  logic        br_taken;
  logic [15:0] br_count;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_pc   = 0;
  int m_stat = 0;
  int m_tk   = 0;
  int m_cnt  = 0;
`ifdef PC_BRCNT_EN
  int cnt_en = 1;
`else
  int cnt_en = 0;
`endif

  pc_branch_unit dut (
    .clk(clk), .pc_rst(pc_rst), .pc_write(pc_write), .pc_sel(pc_sel),
    .br_sel(br_sel), .br_neg(br_neg), .cond_mask(cond_mask), .imm(imm),
    .stat_en(stat_en), .stat_in(stat_in), .pc_out(pc_out),
    .stat_out(stat_out), .br_taken(br_taken), .br_count(br_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"}, int'(pc_out), m_pc);
    check({tag, ".stat"}, int'(stat_out), m_stat);
    check({tag, ".taken"}, int'(br_taken), m_tk);
    check({tag, ".count"}, int'(br_count), m_cnt);
  endtask

  task automatic model_reset();
    m_pc = 0; m_stat = 0; m_tk = 0; m_cnt = 0;
  endtask

  // Apply one edge of stimulus, advance the model by the spec rules, check.
  task automatic step(input string tag, input bit pw, input bit ps, input bit bs,
                      input bit bn, input int mask, input int im,
                      input bit se, input int si, input bit verbose);
    bit hit, c;
    pc_write = pw; pc_sel = ps; br_sel = bs; br_neg = bn;
    cond_mask = mask[3:0]; imm = im[15:0]; stat_en = se; stat_in = si[3:0];
    if (pw) begin
      if (!ps) begin
        m_pc = (m_pc + 1) % 65536;
        m_tk = 0;
      end else begin
        hit = ((mask & m_stat) != 0);
        c   = bn ? !hit : hit;
        if (c) begin
          m_pc = bs ? (m_pc + im) % 65536 : im;
          m_tk = 1;
          if (cnt_en != 0 && m_cnt < 65535) m_cnt++;
        end else begin
          m_tk = 0;
        end
      end
    end
    if (se) m_stat = si;
    @(posedge clk);
    #1;
    pc_write = 1'b0; stat_en = 1'b0;
    if (verbose) begin
      $display("step %s: pw=%0b sel=%0b rel=%0b neg=%0b mask=%h imm=%h pc=%h stat=%h tk=%0b cnt=%h",
               tag, pw, ps, bs, bn, mask[3:0], im[15:0], pc_out, stat_out, br_taken, br_count);
      check_all(tag);
    end
  endtask

  initial begin
    pc_rst = 1'b0; pc_write = 1'b0; pc_sel = 1'b0; br_sel = 1'b0; br_neg = 1'b0;
    cond_mask = '0; imm = '0; stat_en = 1'b0; stat_in = '0;

    // Async reset, checked before any clock edge.
    #2 pc_rst = 1'b1;
    #1 check_all("reset_async");
    @(posedge clk); #1;
    pc_rst = 1'b0;
    check_all("reset_held");

    // Sequential increments.
    step("inc1", 1, 0, 0, 0, 0, 0, 0, 0, 1);
    step("inc2", 1, 0, 0, 0, 0, 0, 0, 0, 1);
    step("inc3", 1, 0, 0, 0, 0, 0, 0, 0, 1);

    // Reset between edges with a pending strobe: cleared immediately, strobe discarded.
    #2;
    pc_write = 1'b1; pc_sel = 1'b0; pc_rst = 1'b1;
    model_reset();
    #1 check_all("rst_mid");
    @(posedge clk); #1;
    check_all("rst_discard");
    pc_write = 1'b0; pc_rst = 1'b0;

    // Status load then masked absolute branch, taken and negated.
    step("stat_z", 0, 0, 0, 0, 0, 0, 1, 1, 1);
    step("br_abs", 1, 1, 0, 0, 1, 16'h0040, 0, 0, 1);
    step("br_absn", 1, 1, 0, 1, 1, 16'h0080, 0, 0, 1);

    // Relative wrap both directions.
    step("to_0010", 1, 1, 0, 1, 0, 16'h0010, 0, 0, 1);
    step("rel_neg", 1, 1, 1, 1, 0, 16'hFFF0, 0, 0, 1);
    step("to_fffe", 1, 1, 0, 1, 0, 16'hFFFE, 0, 0, 1);
    step("rel_wrap", 1, 1, 1, 1, 0, 16'h0003, 0, 0, 1);

    // Increment wrap and never-taken encoding.
    step("to_ffff", 1, 1, 0, 1, 0, 16'hFFFF, 0, 0, 1);
    step("inc_wrap", 1, 0, 0, 0, 0, 0, 0, 0, 1);
    step("never", 1, 1, 0, 0, 0, 16'h1234, 0, 0, 1);

    // Same-edge status load uses old flags; next edge sees new flags.
    step("stat_clr", 0, 0, 0, 0, 0, 0, 1, 0, 1);
    step("same_edge", 1, 1, 0, 0, 4, 16'h1234, 1, 4, 1);
    step("next_edge", 1, 1, 0, 0, 4, 16'h1234, 0, 0, 1);

    // Idle edge: everything holds.
    step("idle", 0, 1, 0, 1, 0, 16'h5555, 0, 0, 1);

    // Random strobes against the model.
    for (int i = 0; i < 300; i++) begin
      step("rnd", ($urandom_range(0, 3) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
           $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 65535),
           $urandom_range(0, 1), $urandom_range(0, 15), 1);
    end

`ifdef PC_BRCNT_EN
    // Counter from reset: five taken branches.
    pc_rst = 1'b1; model_reset();
    #1 pc_rst = 1'b0;
    for (int i = 0; i < 5; i++) step("cnt5", 1, 1, 1, 1, 0, 16'h0002, 0, 0, 1);
    check("cnt_five", int'(br_count), 5);
    // Drive toward saturation, then three more taken branches.
    for (int i = 0; i < 65529; i++) step("sat", 1, 1, 1, 1, 0, 16'h0001, 0, 0, 0);
    check_all("cnt_fffe");
    for (int i = 0; i < 3; i++) step("cnt_sat", 1, 1, 1, 1, 0, 16'h0001, 0, 0, 1);
    check("cnt_ffff", int'(br_count), 65535);
`else
    check("cnt_zero", int'(br_count), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
